// File: rtl/frame_cropper_pkg.sv
// Shared types and constants for the frame cropper and its raster counter.
package frame_cropper_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int TUSER_SOF_BIT = 0;

endpackage

// File: rtl/frame_cropper_if.sv
// Input and output pixel streams of the cropper, bundled as one interface.
interface frame_cropper_if #(
  parameter int PIXEL_BIT_WIDTH = 10
);
  import frame_cropper_pkg::*;

  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata;
  logic                       m_axis_tuser;
  logic                       m_axis_tlast;

  // The cropper itself: consumes s_axis, produces m_axis.
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

  // The environment: feeds s_axis, sinks m_axis.
  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

endinterface

// File: rtl/frame_cropper_raster_position_counter.sv
// Raster position of the next pixel in an IN_ROWS x IN_COLS frame, advanced per accepted pixel.
module raster_position_counter #(
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20,
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1,
  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_adv,
  output logic [CW-1:0] o_col_cnt,
  output logic [RW-1:0] o_row_cnt,
  output logic          o_first_pos,
  output logic          o_last_pos
);

  localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IN_ROWS - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_last_col;
  logic          w_last_row;

  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col_cnt   = r_col;
  assign o_row_cnt   = r_row;
  assign o_first_pos = (r_col == '0) && (r_row == '0);
  assign o_last_pos  = w_last_col && w_last_row;

endmodule

// File: rtl/frame_cropper.sv
// Forwards the OUT_ROWS x OUT_COLS window of each raster frame, tagging start-of-frame and end-of-line.
module frame_cropper
  import frame_cropper_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20,
  parameter int OUT_ROWS        = 10,
  parameter int OUT_COLS        = 10,
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1,
  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  frame_cropper_if.slave bus,
  input  logic [CW-1:0] crop_x0,
  input  logic [RW-1:0] crop_y0,
  output logic          frame_done
);

  if (OUT_COLS > IN_COLS || OUT_ROWS > IN_ROWS) begin : g_bad_geometry
    $fatal(1, "frame_cropper: crop window larger than input frame");
  end

  localparam int CSW = $clog2(IN_COLS + 1);
  localparam int RSW = $clog2(IN_ROWS + 1);
  localparam logic [CW-1:0] MAX_X0 = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] MAX_Y0 = RW'(IN_ROWS - OUT_ROWS);

  function automatic logic [CW-1:0] clamp_x(input logic [CW-1:0] x);
    return (x > MAX_X0) ? MAX_X0 : x;
  endfunction

  function automatic logic [RW-1:0] clamp_y(input logic [RW-1:0] y);
    return (y > MAX_Y0) ? MAX_Y0 : y;
  endfunction

  state_t                     r_state, w_state_nxt;
  logic                       w_hs_in;
  logic [CW-1:0]              w_col_cnt, r_x0, w_x0;
  logic [RW-1:0]              w_row_cnt, r_y0, w_y0;
  logic                       w_first_pos, w_last_pos;
  logic [CSW-1:0]             w_col_ext, w_x0_ext;
  logic [RSW-1:0]             w_row_ext, w_y0_ext;
  logic                       w_in_win, w_sof, w_eol;
  logic                       r_tvalid_p1, r_tlast_p1, r_frame_done_p1;
  logic [PIXEL_BIT_WIDTH-1:0] r_tdata_p1;
  logic [TUSER_SOF_BIT:0]     r_tuser_p1;

  assign bus.s_axis_tready = !r_tvalid_p1 || bus.m_axis_tready;
  assign w_hs_in           = bus.s_axis_tvalid && bus.s_axis_tready;

  raster_position_counter #(
    .IN_ROWS (IN_ROWS),
    .IN_COLS (IN_COLS)
  ) u_pos (
    .clk         (clk),
    .reset       (reset),
    .i_adv       (w_hs_in),
    .o_col_cnt   (w_col_cnt),
    .o_row_cnt   (w_row_cnt),
    .o_first_pos (w_first_pos),
    .o_last_pos  (w_last_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs_in && w_first_pos && !w_last_pos) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_hs_in && w_last_pos)                 w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // While idle the live crop inputs are used directly, so a frame that starts
  // right after the previous one ends still sees the newest crop setting.
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      r_x0 <= clamp_x(crop_x0);
      r_y0 <= clamp_y(crop_y0);
    end
  end

  assign w_x0 = (r_state == IDLE) ? clamp_x(crop_x0) : r_x0;
  assign w_y0 = (r_state == IDLE) ? clamp_y(crop_y0) : r_y0;

  assign w_col_ext = CSW'(w_col_cnt);
  assign w_x0_ext  = CSW'(w_x0);
  assign w_row_ext = RSW'(w_row_cnt);
  assign w_y0_ext  = RSW'(w_y0);

  assign w_in_win = (w_col_ext >= w_x0_ext) && (w_col_ext < w_x0_ext + CSW'(OUT_COLS)) &&
                    (w_row_ext >= w_y0_ext) && (w_row_ext < w_y0_ext + RSW'(OUT_ROWS));
  assign w_sof    = (w_col_cnt == w_x0) && (w_row_cnt == w_y0);
  assign w_eol    = (w_col_ext == w_x0_ext + CSW'(OUT_COLS - 1));

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tvalid_p1     <= 1'b0;
      r_tdata_p1      <= '0;
      r_tuser_p1      <= '0;
      r_tlast_p1      <= 1'b0;
      r_frame_done_p1 <= 1'b0;
    end else begin
      r_frame_done_p1 <= w_hs_in && w_last_pos;
      if (w_hs_in && w_in_win) begin
        r_tvalid_p1               <= 1'b1;
        r_tdata_p1                <= bus.s_axis_tdata;
        r_tuser_p1[TUSER_SOF_BIT] <= w_sof;
        r_tlast_p1                <= w_eol;
      end else if (r_tvalid_p1 && bus.m_axis_tready) begin
        r_tvalid_p1 <= 1'b0;
      end
    end
  end

  assign bus.m_axis_tvalid = r_tvalid_p1;
  assign bus.m_axis_tdata  = r_tdata_p1;
  assign bus.m_axis_tuser  = r_tuser_p1[TUSER_SOF_BIT];
  assign bus.m_axis_tlast  = r_tlast_p1;
  assign frame_done        = r_frame_done_p1;

endmodule

// File: tb/tb_frame_cropper.sv
// Self-checking bench for frame_cropper: directed scenarios plus randomized handshakes and data.
module tb_frame_cropper;

  localparam int W    = 10;
  localparam int IR   = 20;
  localparam int IC   = 20;
  localparam int OR   = 10;
  localparam int OC   = 10;
  localparam int NPIX = IR * IC;

  typedef struct packed {
    logic [W-1:0] d;
    logic         u;
    logic         l;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] crop_x0;
  logic [4:0] crop_y0;
  logic       frame_done;

  frame_cropper_if #(.PIXEL_BIT_WIDTH(W)) bus ();

  frame_cropper #(
    .PIXEL_BIT_WIDTH (W),
    .IN_ROWS         (IR),
    .IN_COLS         (IC),
    .OUT_ROWS        (OR),
    .OUT_COLS        (OC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .crop_x0    (crop_x0),
    .crop_y0    (crop_y0),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  bit           rdy_rand = 1'b0;
  int           vpct = 100;
  logic [W-1:0] pix [NPIX];
  beat_t        exp_q [$];
  beat_t        last_beat;
  logic [W-1:0] last_sof_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: walk the frame in raster order and keep the clamped window.
  task automatic build_expect(input int cx, input int cy);
    int x0, y0, r, c;
    x0 = (cx > IC - OC) ? IC - OC : cx;
    y0 = (cy > IR - OR) ? IR - OR : cy;
    for (int p = 0; p < NPIX; p++) begin
      r = p / IC;
      c = p % IC;
      if (c >= x0 && c < x0 + OC && r >= y0 && r < y0 + OR)
        exp_q.push_back('{d: pix[p], u: (r == y0 && c == x0), l: (c == x0 + OC - 1)});
    end
  endtask

  task automatic fill_ramp();
    for (int p = 0; p < NPIX; p++) pix[p] = W'(p);
  endtask

  task automatic fill_random();
    for (int p = 0; p < NPIX; p++) pix[p] = W'($urandom);
  endtask

  // Offers pixels with probability vpct; optionally retargets the crop after chg_at accepted pixels.
  task automatic send_frame(input int nsend, input int chg_at, input int nx, input int ny);
    int i, guard;
    bit hs;
    i = 0;
    guard = 0;
    while (i < nsend && guard < 20000) begin
      bus.s_axis_tvalid = ($urandom_range(0, 99) < vpct);
      bus.s_axis_tdata  = pix[i];
      @(negedge clk);
      hs = bus.s_axis_tvalid && bus.s_axis_tready;
      @(posedge clk);
      #1;
      if (hs) begin
        i++;
        if (i == chg_at) begin
          crop_x0 = 5'(nx);
          crop_y0 = 5'(ny);
        end
      end
      check("frame_done", 32'(frame_done), 32'(hs && i == NPIX));
      guard++;
    end
    bus.s_axis_tvalid = 1'b0;
    if (i < nsend) check("send_timeout", 32'(i), 32'(nsend));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.m_axis_tvalid) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    check("drain_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    bus.m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: sampled mid-cycle, a beat transfers at the following rising edge.
  logic         stall_prev = 1'b0;
  logic [W+1:0] prev_out;
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      check("s_tready", 32'(bus.s_axis_tready), 32'(!bus.m_axis_tvalid || bus.m_axis_tready));
      if (stall_prev)
        check("stall_hold", 32'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}),
              32'({1'b1, prev_out}));
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(bus.m_axis_tdata), 32'h7fffffff);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 32'({bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast}), 32'(e));
        end
        last_beat = '{d: bus.m_axis_tdata, u: bus.m_axis_tuser, l: bus.m_axis_tlast};
        if (bus.m_axis_tuser) last_sof_d = bus.m_axis_tdata;
      end
      stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_out   = {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    crop_x0 = 5'd0;
    crop_y0 = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
    check("rst_tuser", 32'(bus.m_axis_tuser), 32'd0);
    check("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ramp, crop at origin
    fill_ramp();
    build_expect(0, 0);
    send_frame(NPIX, -1, 0, 0);
    drain();
    check("s1_last_beat", 32'(last_beat), 32'({10'd189, 1'b0, 1'b1}));

    // Ramp, crop (10,10)
    crop_x0 = 5'd10;
    crop_y0 = 5'd10;
    build_expect(10, 10);
    send_frame(NPIX, -1, 0, 0);
    drain();
    check("s2_sof", 32'(last_sof_d), 32'd210);
    check("s2_last_beat", 32'(last_beat), 32'({10'd399, 1'b0, 1'b1}));

    // Out-of-range crop is clamped
    crop_x0 = 5'd15;
    crop_y0 = 5'd17;
    build_expect(15, 17);
    send_frame(NPIX, -1, 0, 0);
    drain();
    check("s3_sof", 32'(last_sof_d), 32'd210);

    // Random backpressure and gaps
    crop_x0 = 5'd0;
    crop_y0 = 5'd0;
    rdy_rand = 1'b1;
    vpct = 70;
    build_expect(0, 0);
    send_frame(NPIX, -1, 0, 0);
    drain();

    // Crop change mid-frame applies to the next, back-to-back frame
    rdy_rand = 1'b0;
    vpct = 100;
    build_expect(0, 0);
    send_frame(NPIX, 50, 5, 5);
    build_expect(5, 5);
    send_frame(NPIX, -1, 0, 0);
    drain();
    check("s5_sof", 32'(last_sof_d), 32'd105);
    check("s5_last_beat", 32'(last_beat), 32'({10'd294, 1'b0, 1'b1}));

    // Reset mid-frame abandons it
    crop_x0 = 5'd0;
    crop_y0 = 5'd0;
    build_expect(0, 0);
    send_frame(150, -1, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("mid_rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
    check("mid_rst_tuser", 32'(bus.m_axis_tuser), 32'd0);
    check("mid_rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    build_expect(0, 0);
    send_frame(NPIX, -1, 0, 0);
    drain();
    check("s6_last_beat", 32'(last_beat), 32'({10'd189, 1'b0, 1'b1}));

    // Random data, random crop, random handshakes
    for (int f = 0; f < 2; f++) begin
      int rx, ry;
      rx = $urandom_range(0, IC - 1);
      ry = $urandom_range(0, IR - 1);
      crop_x0 = 5'(rx);
      crop_y0 = 5'(ry);
      rdy_rand = 1'b1;
      vpct = 70;
      fill_random();
      build_expect(rx, ry);
      send_frame(NPIX, -1, 0, 0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
